// File: rtl/iic_pkg.sv
// Shared constants for the I2C bus-line conditioner.
package iic_pkg;

  localparam int   IIC_SYNC_STAGES_DEF = 2;
  localparam int   IIC_FILT_LEN_DEF    = 3;
  localparam logic IIC_BUS_IDLE        = 1'b1;

endpackage

// File: rtl/iic_line_filter.sv
// One I2C line: pad synchronizer, glitch filter and registered edge pulses.
// The filtered level only moves after FILT_LEN consecutive synchronized
// samples disagree with it. 'flip' is the level change that the next edge
// will commit; it is decoded from flops only, so the parent can register
// events that line up exactly with the level update.
module iic_line_filter
  import iic_pkg::*;
#(
  parameter int SYNC_STAGES = IIC_SYNC_STAGES_DEF,
  parameter int FILT_LEN    = IIC_FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic flip
);

  localparam int             CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   differ;

  assign differ = sync_q[SYNC_STAGES-1] != level;
  assign flip   = differ && (cnt_q == CNT_LAST);

  // Synchronizer chain, idle-high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IIC_BUS_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  // Glitch counter, filtered level and edge pulses coincident with the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      level <= IIC_BUS_IDLE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= flip & ~level;
      fall <= flip & level;
      if (flip) begin
        level <= ~level;
        cnt_q <= '0;
      end else if (differ) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/iic_bus_cond.sv
// I2C bus-line conditioner: filtered SCL/SDA, SCL edge pulses, START/STOP
// detection, bus-busy tracking and optional arbitration-loss flag.
// Build option: define IIC_BUS_COND_ARB_EN to implement arbitration-loss
// detection; otherwise arb_lost is tied low and sda_o/sda_oen_n/clr_arb
// are ignored.
// For SYNC_STAGES+FILT_LEN edges after reset the filters may still be
// converging onto a bus that was already active, so START/STOP are muted
// during that window to avoid reporting a transfer already in progress.
module iic_bus_cond
  import iic_pkg::*;
#(
  parameter int SYNC_STAGES = IIC_SYNC_STAGES_DEF,
  parameter int FILT_LEN    = IIC_FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  input  logic sda_o,
  input  logic sda_oen_n,
  input  logic clr_arb,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic arb_lost
);

  localparam int            SW          = $clog2(SYNC_STAGES + FILT_LEN + 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SYNC_STAGES + FILT_LEN);

  logic          scl_flip;
  logic          sda_flip;
  logic          sda_rise_unused;
  logic          sda_fall_unused;
  logic [SW-1:0] settle_q;
  logic          settled;
  logic          scl_high_held;
  logic          start_nxt;
  logic          stop_nxt;

  iic_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_scl (
    .clk    (clk),
    .rst    (rst),
    .line_in(scl_i),
    .level  (scl_f),
    .rise   (scl_rise),
    .fall   (scl_fall),
    .flip   (scl_flip)
  );

  iic_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sda (
    .clk    (clk),
    .rst    (rst),
    .line_in(sda_i),
    .level  (sda_f),
    .rise   (sda_rise_unused),
    .fall   (sda_fall_unused),
    .flip   (sda_flip)
  );

  assign settled       = (settle_q == '0);
  assign scl_high_held = scl_f & ~scl_flip;
  assign start_nxt     = settled & scl_high_held & sda_flip & sda_f;
  assign stop_nxt      = settled & scl_high_held & sda_flip & ~sda_f;

  // START/STOP pulses, bus-busy tracking and post-reset settle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
      settle_q  <= SETTLE_INIT;
    end else begin
      start_det <= start_nxt;
      stop_det  <= stop_nxt;
      if (start_nxt) begin
        bus_busy <= 1'b1;
      end else if (stop_nxt) begin
        bus_busy <= 1'b0;
      end
      if (!settled) begin
        settle_q <= settle_q - 1'b1;
      end
    end
  end

`ifdef IIC_BUS_COND_ARB_EN
  logic arb_set;

  // Compare against the SDA level that will be visible in the scl_rise cycle.
  assign arb_set = scl_flip & ~scl_f & ~(sda_f ^ sda_flip) & sda_o & ~sda_oen_n;

  // Sticky arbitration-lost flag; a simultaneous set beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_lost <= 1'b0;
    end else if (arb_set) begin
      arb_lost <= 1'b1;
    end else if (clr_arb) begin
      arb_lost <= 1'b0;
    end
  end
`else
  logic arb_inputs_unused;

  assign arb_inputs_unused = ^{sda_o, sda_oen_n, clr_arb};
  assign arb_lost          = 1'b0;
`endif

endmodule

// File: tb/tb_iic_bus_cond.sv
// Bench for iic_bus_cond with default parameters. A window-based reference
// model (pad history per edge) predicts every output each cycle.
module tb_iic_bus_cond;

  localparam int S = 2;
  localparam int F = 3;
`ifdef IIC_BUS_COND_ARB_EN
  localparam logic ARB_ON = 1'b1;
`else
  localparam logic ARB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_i = 1'b1, sda_i = 1'b1, sda_o = 1'b0, sda_oen_n = 1'b1, clr_arb = 1'b0;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, arb_lost;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iic_bus_cond dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_o(sda_o),
    .sda_oen_n(sda_oen_n), .clr_arb(clr_arb), .scl_f(scl_f), .sda_f(sda_f),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
    .stop_det(stop_det), .bus_busy(bus_busy), .arb_lost(arb_lost)
  );

  // Reference model: h[j] is the pad value sampled j edges ago. The filtered
  // level flips when the F samples that have crossed the synchronizer all
  // disagree with it.
  logic [S+F-1:0] h_scl, h_sda;
  logic m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_arb;
  logic n_scl, n_sda;
  int   m_age;

  function automatic logic filt(input logic [S+F-1:0] h, input logic lvl);
    logic all_diff;
    all_diff = 1'b1;
    for (int j = S; j < S + F; j++) if (h[j] == lvl) all_diff = 1'b0;
    return all_diff ? ~lvl : lvl;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      h_scl = '1; h_sda = '1;
      m_scl = 1'b1; m_sda = 1'b1;
      m_rise = 1'b0; m_fall = 1'b0; m_start = 1'b0; m_stop = 1'b0;
      m_busy = 1'b0; m_arb = 1'b0; m_age = 0;
    end else begin
      h_scl = {h_scl[S+F-2:0], scl_i};
      h_sda = {h_sda[S+F-2:0], sda_i};
      n_scl = filt(h_scl, m_scl);
      n_sda = filt(h_sda, m_sda);
      if (m_age < 1000) m_age++;
      m_rise  = n_scl & ~m_scl;
      m_fall  = ~n_scl & m_scl;
      m_start = (m_age > S + F) && m_scl && n_scl && m_sda && !n_sda;
      m_stop  = (m_age > S + F) && m_scl && n_scl && !m_sda && n_sda;
      if (m_start) m_busy = 1'b1;
      else if (m_stop) m_busy = 1'b0;
      if (ARB_ON && m_rise && !n_sda && sda_o && !sda_oen_n) m_arb = 1'b1;
      else if (clr_arb) m_arb = 1'b0;
      m_scl = n_scl;
      m_sda = n_sda;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
    cyc(); cyc();
    total++;
    if ({scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, arb_lost} !== 8'b1100_0000) begin
      bad++;
      $display("FAIL reset_values got=%b want=11000000",
               {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, arb_lost});
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    total++;
    if ({scl_f, sda_f, start_det, stop_det, bus_busy} !== 5'b11000) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=11000", {scl_f, sda_f, start_det, stop_det, bus_busy});
    end
  endtask

  task automatic test_glitch();
    sda_i = 1'b0; cyc(); cyc();
    sda_i = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      total++;
      if (sda_f !== 1'b1 || start_det !== 1'b0) begin
        bad++;
        $display("FAIL glitch_reject edge=%0d sda_f=%b start=%b want sda_f=1 start=0", e, sda_f, start_det);
      end
    end
    sda_i = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      total++;
      if (sda_f !== (e < 5) || start_det !== (e == 5)) begin
        bad++;
        $display("FAIL glitch_accept edge=%0d sda_f=%b start=%b want sda_f=%b start=%b",
                 e, sda_f, start_det, e < 5, e == 5);
      end
    end
    total++;
    if (bus_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start got=%b want=1", bus_busy);
    end
  endtask

  task automatic test_start_stop();
    int seen;
    sda_i = 1'b1; seen = 0;
    for (int e = 1; e <= 12 && seen == 0; e++) begin
      cyc();
      if (stop_det) seen = e;
    end
    total++;
    if (seen != 5 || bus_busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_edge got_edge=%0d busy=%b want_edge=5 busy=0", seen, bus_busy);
    end
    sda_i = 1'b0; seen = 0;
    for (int e = 1; e <= 12 && seen == 0; e++) begin
      cyc();
      if (start_det) seen = e;
    end
    total++;
    if (seen != 5 || bus_busy !== 1'b1) begin
      bad++;
      $display("FAIL start_edge got_edge=%0d busy=%b want_edge=5 busy=1", seen, bus_busy);
    end
  endtask

  task automatic test_repeated_start();
    int starts, stops, busy_drop;
    starts = 0; stops = 0; busy_drop = 0;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: scl_i = 1'b0;
        1: sda_i = 1'b1;
        2: scl_i = 1'b1;
        default: sda_i = 1'b0;
      endcase
      for (int i = 0; i < 7; i++) begin
        cyc();
        if (start_det) starts++;
        if (stop_det) stops++;
        if (bus_busy !== 1'b1) busy_drop++;
      end
    end
    total++;
    if (starts != 1 || stops != 0 || busy_drop != 0) begin
      bad++;
      $display("FAIL repeated_start starts=%0d stops=%0d busy_low_cycles=%0d want 1/0/0", starts, stops, busy_drop);
    end
    sda_i = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    total++;
    if (bus_busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_stop got=%b want=0", bus_busy);
    end
  endtask

  task automatic test_simultaneous();
    for (int r = 0; r < 2; r++) begin
      scl_i = r[0]; sda_i = r[0];
      for (int e = 1; e <= 8; e++) begin
        cyc();
        total++;
        if (scl_f !== ((e < 5) ? ~r[0] : r[0]) || sda_f !== ((e < 5) ? ~r[0] : r[0]) ||
            start_det !== 1'b0 || stop_det !== 1'b0 || bus_busy !== 1'b0) begin
          bad++;
          $display("FAIL simultaneous r=%0d edge=%0d scl_f=%b sda_f=%b start=%b stop=%b busy=%b",
                   r, e, scl_f, sda_f, start_det, stop_det, bus_busy);
        end
      end
    end
  endtask

  task automatic test_arb();
    scl_i = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    sda_i = 1'b0; sda_o = 1'b1; sda_oen_n = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    scl_i = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      total++;
      if (scl_rise !== (e == 5) || arb_lost !== (ARB_ON && e >= 5)) begin
        bad++;
        $display("FAIL arb_set edge=%0d rise=%b arb=%b want rise=%b arb=%b",
                 e, scl_rise, arb_lost, e == 5, ARB_ON && e >= 5);
      end
    end
    clr_arb = 1'b1; cyc(); clr_arb = 1'b0;
    total++;
    if (arb_lost !== 1'b0) begin
      bad++;
      $display("FAIL arb_clear got=%b want=0", arb_lost);
    end
    scl_i = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    scl_i = 1'b1; clr_arb = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      total++;
      if (arb_lost !== (ARB_ON && e == 5)) begin
        bad++;
        $display("FAIL arb_set_beats_clear edge=%0d arb=%b want=%b", e, arb_lost, ARB_ON && e == 5);
      end
    end
    clr_arb = 1'b0; sda_oen_n = 1'b1; sda_o = 1'b0;
    sda_i = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; scl_i = 1'b1; sda_i = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      total++;
      if (sda_f !== (e < 5) || start_det !== 1'b0 || bus_busy !== 1'b0 || arb_lost !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid edge=%0d sda_f=%b start=%b busy=%b arb=%b want sda_f=%b 0 0 0",
                 e, sda_f, start_det, bus_busy, arb_lost, e < 5);
      end
    end
    sda_i = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
  endtask

  task automatic test_random();
    int hold;
    logic [7:0] got, want;
    int shown;
    hold = 0; shown = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        scl_i = $urandom_range(0, 1);
        sda_i = $urandom_range(0, 1);
        hold  = $urandom_range(1, 7);
      end
      hold--;
      sda_o     = $urandom_range(0, 1);
      sda_oen_n = ($urandom_range(0, 3) == 0);
      clr_arb   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      cyc();
      got  = {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, arb_lost};
      want = {m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_arb};
      total++;
      if (got !== want) begin
        bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cyc=%0d got=%b want=%b (scl_f sda_f rise fall start stop busy arb)", i, got, want);
        end
      end
    end
    rst = 1'b0; clr_arb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start_stop();
    test_repeated_start();
    test_simultaneous();
    test_arb();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iic_bus_cond.md
# iic_bus_cond

I2C bus-line conditioner and event detector that sits between the SCL/SDA input pads and the I2C master core. It synchronizes and glitch-filters `scl_i`/`sda_i` and produces clean filtered levels and one-cycle SCL edge pulses. It also detects START/STOP conditions, tracks bus-busy, and optionally flags arbitration loss by comparing the core's SDA drive against the filtered bus level. Everything runs in the system clock domain and feeds the master's ACK-receive and state logic.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops per line; minimum 2.
- `FILT_LEN`, default 3: consecutive stable samples required to accept a level change; minimum 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `scl_i` in 1: raw SCL pad input, asynchronous.
- `sda_i` in 1: raw SDA pad input, asynchronous.
- `sda_o` in 1: SDA value the master core is driving.
- `sda_oen_n` in 1: master SDA output enable, active-low.
- `clr_arb` in 1: one-cycle clear of `arb_lost`.
- `scl_f` out 1: filtered SCL level.
- `sda_f` out 1: filtered SDA level.
- `scl_rise` out 1: one-cycle pulse on filtered SCL 0→1.
- `scl_fall` out 1: one-cycle pulse on filtered SCL 1→0.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `bus_busy` out 1: high from START until STOP.
- `arb_lost` out 1: sticky arbitration-lost flag.

## Operation
- Reset values:
  - Synchronizer flops, `scl_f`, `sda_f`: 1 (idle bus).
  - `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `bus_busy`, `arb_lost`: 0.
  - Filter counters: 0.
- Per-line filter:
  - The synchronized sample is compared with the filtered level.
  - A counter of width $clog2(FILT_LEN+1) increments while the two differ and clears to 0 whenever they match.
  - When the counter would reach FILT_LEN, the filtered level toggles and the counter clears.
  - A mismatch that lasts fewer than FILT_LEN cycles is discarded.
- Edge pulses:
  - Registered; high for exactly the first cycle in which `scl_f` shows its new value.
- START:
  - Condition: `sda_f` falls while `scl_f` is 1 and `scl_f` does not change in the same cycle.
  - Response: `start_det` pulses and `bus_busy` becomes 1. A repeated START while busy still pulses and `bus_busy` stays 1.
- STOP:
  - Condition: `sda_f` rises while `scl_f` is 1 and `scl_f` does not change in the same cycle.
  - Response: `stop_det` pulses and `bus_busy` becomes 0.
- SCL and SDA filtered levels changing in the same cycle: no START or STOP is reported.
- Arbitration, evaluated only on the `scl_rise` cycle:
  - Set condition: `sda_oen_n`=0, `sda_o`=1 and `sda_f`=0. `arb_lost` sets and stays set.
  - `clr_arb` clears it. If set and clear occur in the same cycle, set wins.
  - `stop_det` does not clear it.
- Reset mid-transfer: all state returns to reset values at the next edge. Bus activity already in progress is not reported as START.

## Timing
- Pad-to-filtered latency for a held change: SYNC_STAGES+FILT_LEN rising edges, counting the first capturing edge as 1. With the defaults this is 5 cycles.
- Edge, START and STOP pulses are coincident with the filtered-level update. They add zero cycles beyond the filter latency.
- `bus_busy` and `arb_lost` update on the same edge as the pulse that causes them.
- No combinational path runs from any input to any output.

## Configuration
- Macro: `IIC_BUS_COND_ARB_EN`.
- Defined: arbitration-loss detection is implemented as described above.
- Undefined:
  - `arb_lost` is tied to 0.
  - `sda_o`, `sda_oen_n` and `clr_arb` are unused, but the ports remain present.
  - All other behaviour is identical.

## Structure
- Shared package `iic_pkg` holds:
  - Default constants `IIC_SYNC_STAGES_DEF` = 2 and `IIC_FILT_LEN_DEF` = 3.
  - The bus-idle level constant (1).
- Sub-module `iic_line_filter` contains the synchronizer, glitch counter, filtered level and rise/fall pulses for one line. It is instantiated once for SCL and once for SDA.
- The top level holds START/STOP detection, busy tracking and arbitration logic.

## Test plan
All scenarios use the defaults (SYNC_STAGES=2, FILT_LEN=3).
- Reset then idle: hold `rst`=1 for 2 cycles with pads at 1 → `scl_f`=`sda_f`=1 and every pulse, `bus_busy` and `arb_lost` are 0.
- Glitch rejection: drive `sda_i` low for 2 cycles with `scl_i`=1 → `sda_f` stays 1 and no `start_det`. Drive it low for 3 cycles → `sda_f`=0 on edge 5 and `start_det` pulses once.
- START/STOP: SDA falls while SCL high → `start_det` pulse and `bus_busy`=1. SDA rises while SCL high → `stop_det` pulse and `bus_busy`=0.
- Repeated START while busy → `start_det` pulses and `bus_busy` remains 1 throughout.
- Simultaneous change: switch `scl_i` and `sda_i` on the same cycle → both filtered levels update on the same edge and neither `start_det` nor `stop_det` pulses.
- Arbitration (macro defined): set `sda_oen_n`=0 and `sda_o`=1 with `sda_i`=0, then give SCL a rising edge → `arb_lost`=1 on the `scl_rise` cycle. `clr_arb` clears it. With the macro undefined, the same stimulus leaves `arb_lost`=0.
